pixel_bus_arbiter: RTL and testbench

Round-robin arbiter and sequencer for the shared 32-bit write-back path of the image-sharpening extension. Four requesters (DLX core, sharpen-kernel result, line-buffer refill, debug port) each present a data word. The block grants one requester at a time for a burst of beats that ends on `last`. It drives the select of the 4:1 32-bit mux and presents the muxed word downstream with a valid/ready handshake.

---
 rtl/pixel_bus_arbiter_pkg.sv | 21 ++
 rtl/pixel_bus_arbiter_mux.sv | 13 +
 rtl/pixel_bus_arbiter.sv | 94 +++++++++
 tb/tb_pixel_bus_arbiter.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_bus_arbiter_pkg.sv
// pixel_bus_arbiter_pkg: arbiter state encodings, requester count and round-robin search helper
package pixel_bus_arbiter_pkg;

    localparam int ARB_NREQ = 4;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

    // Lowest offset from ptr+1 upward wins; offset 4 wraps back to ptr itself.
    function automatic logic [1:0] rr_next(input logic [ARB_NREQ-1:0] req, input logic [1:0] ptr);
        logic [1:0] idx;
        rr_next = ptr;
        for (int i = ARB_NREQ; i >= 1; i--) begin
            idx = ptr + 2'(i);
            if (req[idx]) rr_next = idx;
        end
    endfunction

endpackage

// File: rtl/pixel_bus_arbiter_mux.sv
// MUX4_32bit: 4:1 mux of 32-bit words
module MUX4_32bit (
    input  logic [1:0]  sel,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] c,
    input  logic [31:0] d,
    output logic [31:0] y
);

    always_comb y = sel[1] ? (sel[0] ? d : c) : (sel[0] ? b : a);

endmodule

// File: rtl/pixel_bus_arbiter.sv
// pixel_bus_arbiter: round-robin burst arbiter for the write-back path; PIXEL_ARB_BURST_LIMIT_EN adds a beat limit and burst_err
module pixel_bus_arbiter
    import pixel_bus_arbiter_pkg::*;
#(
    parameter int MAX_BURST = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ARB_NREQ-1:0] req,
    input  logic [ARB_NREQ-1:0] last,
    input  logic [31:0]         data_a,
    input  logic [31:0]         data_b,
    input  logic [31:0]         data_c,
    input  logic [31:0]         data_d,
    input  logic                out_ready,
    output logic [ARB_NREQ-1:0] gnt,
    output logic [1:0]          sel,
    output logic [31:0]         out_data,
    output logic                out_valid
`ifdef PIXEL_ARB_BURST_LIMIT_EN
    ,
    output logic                burst_err
`endif
);

    if (MAX_BURST < 1) begin : g_bad_max_burst
        $error("MAX_BURST must be at least 1");
    end

    arb_state_t state, state_n;
    logic [1:0] ptr, ptr_n, sel_n;
    logic       xfer, forced, eob;

    assign out_valid = state == ARB_BUSY;
    assign gnt       = out_valid ? ARB_NREQ'(1) << sel : '0;
    assign xfer      = out_valid && out_ready;
    assign eob       = xfer && (last[sel] || forced);

`ifdef PIXEL_ARB_BURST_LIMIT_EN
    localparam int CW = $clog2(MAX_BURST + 1);
    logic [CW-1:0] cnt;

    assign forced = xfer && !last[sel] && cnt == CW'(MAX_BURST - 1);

    // Counter restarts on every grant change, including idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            burst_err <= 1'b0;
        end else begin
            cnt       <= (eob || !out_valid) ? '0 : xfer ? cnt + 1'b1 : cnt;
            burst_err <= forced;
        end
    end
`else
    assign forced = 1'b0;
`endif

    // While busy ptr equals sel, so one search covers both entry and re-arbitration.
    always_comb begin
        state_n = state;
        sel_n   = sel;
        ptr_n   = ptr;
        if ((state == ARB_IDLE || eob) && |req) begin
            state_n = ARB_BUSY;
            sel_n   = rr_next(req, ptr);
            ptr_n   = sel_n;
        end else if (eob) begin
            state_n = ARB_IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ARB_IDLE;
            sel   <= 2'd0;
            ptr   <= 2'd3;
        end else begin
            state <= state_n;
            sel   <= sel_n;
            ptr   <= ptr_n;
        end
    end

    MUX4_32bit u_mux (
        .sel (sel),
        .a   (data_a),
        .b   (data_b),
        .c   (data_c),
        .d   (data_d),
        .y   (out_data)
    );

endmodule

// File: tb/tb_pixel_bus_arbiter.sv
// tb_pixel_bus_arbiter: directed checks of reset, bursts, round-robin, stall, req drop and mid-burst reset
module tb_pixel_bus_arbiter;

    logic        clk, rst, out_ready, out_valid;
    logic [3:0]  req, last, gnt;
    logic [1:0]  sel;
    logic [31:0] data_a, data_b, data_c, data_d, out_data;
`ifdef PIXEL_ARB_BURST_LIMIT_EN
    logic        burst_err;
`endif
    int total = 0;
    int bad   = 0;

    pixel_bus_arbiter #(.MAX_BURST(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .last      (last),
        .data_a    (data_a),
        .data_b    (data_b),
        .data_c    (data_c),
        .data_d    (data_d),
        .out_ready (out_ready),
        .gnt       (gnt),
        .sel       (sel),
        .out_data  (out_data),
        .out_valid (out_valid)
`ifdef PIXEL_ARB_BURST_LIMIT_EN
        ,
        .burst_err (burst_err)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic do_reset();
        rst = 1'b1;
        req = 4'b0;
        last = 4'b0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        total++;
        if (gnt !== 4'b0000 || out_valid !== 1'b0 || sel !== 2'd0) begin
            bad++;
            $display("FAIL reset gnt=%b valid=%b sel=%0d exp 0000/0/0", gnt, out_valid, sel);
        end
    endtask

    task automatic test_single_burst();
        req = 4'b0001;
        for (int b = 1; b <= 3; b++) begin
            @(negedge clk);
            total++;
            if (gnt !== 4'b0001 || out_valid !== 1'b1 || out_data !== 32'haaaa_0000) begin
                bad++;
                $display("FAIL single_beat%0d gnt=%b valid=%b data=%h exp 0001/1/aaaa0000", b, gnt, out_valid, out_data);
            end
            if (b == 3) begin
                last = 4'b0001;
                req = 4'b0;
            end
        end
        @(negedge clk);
        total++;
        if (gnt !== 4'b0000 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL single_idle gnt=%b valid=%b exp 0000/0", gnt, out_valid);
        end
        last = 4'b0;
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp_g [5];
        exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        do_reset();
        req = 4'b1111;
        last = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            total++;
            if (gnt !== exp_g[k] || out_valid !== 1'b1) begin
                bad++;
                $display("FAIL rr_grant%0d gnt=%b valid=%b exp %b/1", k, gnt, out_valid, exp_g[k]);
            end
        end
        req = 4'b0;
        @(negedge clk);
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL rr_idle valid=%b exp 0", out_valid);
        end
        last = 4'b0;
    endtask

    task automatic test_stall();
        req = 4'b0100;
        @(negedge clk);
        total++;
        if (gnt !== 4'b0100 || sel !== 2'd2 || out_data !== 32'hcccc_2222) begin
            bad++;
            $display("FAIL stall_grant gnt=%b sel=%0d data=%h exp 0100/2/cccc2222", gnt, sel, out_data);
        end
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            total++;
            if (gnt !== 4'b0100 || sel !== 2'd2 || out_valid !== 1'b1) begin
                bad++;
                $display("FAIL stall_hold%0d gnt=%b sel=%0d valid=%b exp 0100/2/1", k, gnt, sel, out_valid);
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        total++;
        if (gnt !== 4'b0100 || out_valid !== 1'b1) begin
            bad++;
            $display("FAIL stall_resume gnt=%b valid=%b exp 0100/1", gnt, out_valid);
        end
        last = 4'b0100;
        req = 4'b0;
        @(negedge clk);
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL stall_end valid=%b exp 0", out_valid);
        end
        last = 4'b0;
    endtask

    task automatic test_drop_req();
        req = 4'b0010;
        @(negedge clk);
        req = 4'b0;
        for (int k = 0; k < 4; k++) begin
            total++;
            if (gnt !== 4'b0010 || sel !== 2'd1 || out_data !== 32'hbbbb_1111) begin
                bad++;
                $display("FAIL drop_hold%0d gnt=%b sel=%0d data=%h exp 0010/1/bbbb1111", k, gnt, sel, out_data);
            end
            @(negedge clk);
        end
        last = 4'b0010;
        @(negedge clk);
        total++;
        if (gnt !== 4'b0000 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL drop_release gnt=%b valid=%b exp 0000/0", gnt, out_valid);
        end
        last = 4'b0;
    endtask

    task automatic test_reset_mid_burst();
        req = 4'b1000;
        @(negedge clk);
        total++;
        if (gnt !== 4'b1000 || out_data !== 32'hdddd_3333) begin
            bad++;
            $display("FAIL rstmid_grant gnt=%b data=%h exp 1000/dddd3333", gnt, out_data);
        end
        #2 rst = 1'b1;
        #1;
        total++;
        if (gnt !== 4'b0000 || out_valid !== 1'b0 || sel !== 2'd0) begin
            bad++;
            $display("FAIL rstmid_async gnt=%b valid=%b sel=%0d exp 0000/0/0", gnt, out_valid, sel);
        end
        req = 4'b1001;
        @(negedge clk);
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL rstmid_held valid=%b exp 0", out_valid);
        end
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (gnt !== 4'b0001 || out_valid !== 1'b1) begin
            bad++;
            $display("FAIL rstmid_regrant gnt=%b valid=%b exp 0001/1", gnt, out_valid);
        end
        last = 4'b0001;
        req = 4'b0;
        @(negedge clk);
        last = 4'b0;
    endtask

`ifdef PIXEL_ARB_BURST_LIMIT_EN
    task automatic test_burst_limit();
        do_reset();
        req = 4'b0110;
        for (int b = 1; b <= 4; b++) begin
            @(negedge clk);
            total++;
            if (gnt !== 4'b0010 || burst_err !== 1'b0) begin
                bad++;
                $display("FAIL limit_beat%0d gnt=%b err=%b exp 0010/0", b, gnt, burst_err);
            end
        end
        @(negedge clk);
        total++;
        if (gnt !== 4'b0100 || burst_err !== 1'b1) begin
            bad++;
            $display("FAIL limit_force gnt=%b err=%b exp 0100/1", gnt, burst_err);
        end
        req = 4'b0;
        last = 4'b0100;
        @(negedge clk);
        total++;
        if (burst_err !== 1'b0 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL limit_pulse err=%b valid=%b exp 0/0", burst_err, out_valid);
        end
        last = 4'b0;
    endtask
`endif

    initial begin
        data_a = 32'haaaa_0000;
        data_b = 32'hbbbb_1111;
        data_c = 32'hcccc_2222;
        data_d = 32'hdddd_3333;
        test_reset();
        test_single_burst();
        test_back_to_back();
        test_stall();
        test_drop_req();
        test_reset_mid_burst();
`ifdef PIXEL_ARB_BURST_LIMIT_EN
        test_burst_limit();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
